// File: rtl/uart_rx_core.sv
// UART receiver: 8 data bits, no parity, one stop bit, sampled at bit centres.
// One held byte, with a sticky overrun flag and a one-cycle frame error pulse.
module uart_rx_core #(
  parameter int BAUD   = 115200,
  parameter int CLK_HZ = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  input  logic       data_rd,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       overrun,
  output logic       frame_err,
  output logic       busy_rx
);

  localparam int COUNT = CLK_HZ / BAUD;
  localparam int HALF  = COUNT / 2;
  localparam int CW    = $clog2(COUNT + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_reg;
  logic [1:0]      sync_reg;
  logic            rx_s;
  logic [CW-1:0]   cnt_reg;
  logic [2:0]      bit_idx_reg;
  logic [7:0]      shift_reg;

  assign rx_s    = sync_reg[1];
  assign busy_rx = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      sync_reg    <= 2'b11;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      data_out    <= 8'h00;
      data_valid  <= 1'b0;
      overrun     <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[0], uart_rx};
      frame_err <= 1'b0;
      // A read clears the flags; a byte landing in the same cycle overrides below.
      if (data_rd) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (!rx_s) begin
            state_reg <= START;
            cnt_reg   <= CW'(HALF - 1);
          end
        end
        START: begin
          if (cnt_reg == '0) begin
            if (rx_s) begin
              state_reg <= IDLE;
            end else begin
              state_reg   <= DATA;
              bit_idx_reg <= 3'd0;
              cnt_reg     <= CW'(COUNT - 1);
            end
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        DATA: begin
          if (cnt_reg == '0) begin
            shift_reg <= {rx_s, shift_reg[7:1]};
            cnt_reg   <= CW'(COUNT - 1);
            if (bit_idx_reg == 3'd7) begin
              state_reg <= STOP;
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        STOP: begin
          if (cnt_reg == '0) begin
            // Leave mid-stop-bit so a following start edge is not missed.
            state_reg <= IDLE;
            if (rx_s) begin
              data_out   <= shift_reg;
              data_valid <= 1'b1;
              if (data_valid && !data_rd) begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core at 10 clocks per bit.
// A single process drives the line and watches the outputs on falling edges.
module tb_uart_rx_core;

  logic       clk;
  logic       reset;
  logic       uart_rx;
  logic       data_rd;
  logic [7:0] data_out;
  logic       data_valid;
  logic       overrun;
  logic       frame_err;
  logic       busy_rx;

  uart_rx_core #(.BAUD(5000000), .CLK_HZ(50000000)) dut (
    .clk        (clk),
    .reset      (reset),
    .uart_rx    (uart_rx),
    .data_rd    (data_rd),
    .data_out   (data_out),
    .data_valid (data_valid),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .busy_rx    (busy_rx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks;
  int         errors;
  int         fe_pulses;
  bit         fe_run;
  bit         fe_long;
  bit         busy_seen;
  logic       prev_valid;
  logic [7:0] prev_out;
  logic       prev_ovr;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];

  // One clock step; records every new byte update and frame_err pulse.
  task automatic tick();
    @(negedge clk);
    if (data_valid && (!prev_valid || data_out !== prev_out || (overrun && !prev_ovr)))
      obs_q.push_back(data_out);
    if (frame_err === 1'b1) begin
      if (fe_run) fe_long = 1'b1;
      else fe_pulses++;
    end
    if (busy_rx === 1'b1) busy_seen = 1'b1;
    fe_run     = (frame_err === 1'b1);
    prev_valid = data_valid;
    prev_out   = data_out;
    prev_ovr   = overrun;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input bit push_exp,
                            input bit rd_at_stop);
    if (push_exp) exp_q.push_back(d);
    uart_rx = 1'b0;
    repeat (10) tick();
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      repeat (10) tick();
    end
    uart_rx = stop;
    if (rd_at_stop) begin
      // The stop sample lands on the 98th rising edge after the start bit is driven.
      repeat (7) tick();
      data_rd = 1'b1;
      tick();
      data_rd = 1'b0;
      repeat (2) tick();
    end else begin
      repeat (10) tick();
    end
    uart_rx = 1'b1;
  endtask

  task automatic pulse_rd();
    data_rd = 1'b1;
    tick();
    data_rd = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) tick();
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out got %h want 00", data_out); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", data_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    checks++; if (busy_rx !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_rx); end
    reset = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_frame_err();
    int fe0;
    fe0 = fe_pulses;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (25) tick();
    $display("frame 3C with low stop: frame_err pulses %0d", fe_pulses - fe0);
    checks++; if (fe_pulses - fe0 !== 1) begin errors++; $display("FAIL ferr_count got %0d want 1", fe_pulses - fe0); end
    checks++; if (fe_long !== 1'b0) begin errors++; $display("FAIL ferr_width got long pulse want 1 cycle"); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL ferr_valid got %b want 0", data_valid); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL ferr_data_out got %h want 00", data_out); end
    checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL ferr_no_byte got %0d bytes want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_false_start();
    int fe0;
    fe0 = fe_pulses;
    busy_seen = 1'b0;
    uart_rx = 1'b0;
    repeat (3) tick();
    uart_rx = 1'b1;
    repeat (20) tick();
    $display("glitch 3 clk low: busy seen %b", busy_seen);
    checks++; if (busy_seen !== 1'b1) begin errors++; $display("FAIL glitch_busy_seen got %b want 1", busy_seen); end
    checks++; if (busy_rx !== 1'b0) begin errors++; $display("FAIL glitch_idle got busy %b want 0", busy_rx); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid got %b want 0", data_valid); end
    checks++; if (fe_pulses !== fe0) begin errors++; $display("FAIL glitch_ferr got %0d want %0d", fe_pulses, fe0); end
  endtask

  task automatic test_good_frame();
    int fe0;
    fe0 = fe_pulses;
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    while (obs_q.size() > 0) begin
      logic [7:0] o;
      logic [7:0] e;
      o = obs_q.pop_front();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      $display("rx byte %h expected %h", o, e);
      checks++; if (o !== e) begin errors++; $display("FAIL good_byte got %h want %h", o, e); end
    end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL good_missing got %0d pending want 0", exp_q.size()); exp_q.delete(); end
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL good_data_out got %h want a5", data_out); end
    checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL good_valid got %b want 1", data_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL good_overrun got %b want 0", overrun); end
    checks++; if (fe_pulses !== fe0) begin errors++; $display("FAIL good_ferr got %0d want %0d", fe_pulses, fe0); end
    checks++; if (busy_rx !== 1'b0) begin errors++; $display("FAIL good_busy got %b want 0", busy_rx); end
    pulse_rd();
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL good_read_valid got %b want 0", data_valid); end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h11, 1'b1, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    while (obs_q.size() > 0) begin
      logic [7:0] o;
      logic [7:0] e;
      o = obs_q.pop_front();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      $display("rx byte %h expected %h", o, e);
      checks++; if (o !== e) begin errors++; $display("FAIL b2b_byte got %h want %h", o, e); end
    end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_missing got %0d pending want 0", exp_q.size()); exp_q.delete(); end
    checks++; if (data_out !== 8'h22) begin errors++; $display("FAIL b2b_data_out got %h want 22", data_out); end
    checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1", data_valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun got %b want 1", overrun); end
    pulse_rd();
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL b2b_read_valid got %b want 0", data_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_read_overrun got %b want 0", overrun); end
  endtask

  task automatic test_rd_same_cycle();
    send_frame(8'h66, 1'b1, 1'b1, 1'b0);
    repeat (5) tick();
    send_frame(8'h77, 1'b1, 1'b1, 1'b1);
    repeat (3) tick();
    while (obs_q.size() > 0) begin
      logic [7:0] o;
      logic [7:0] e;
      o = obs_q.pop_front();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      $display("rx byte %h expected %h", o, e);
      checks++; if (o !== e) begin errors++; $display("FAIL rdsame_byte got %h want %h", o, e); end
    end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL rdsame_missing got %0d pending want 0", exp_q.size()); exp_q.delete(); end
    checks++; if (data_out !== 8'h77) begin errors++; $display("FAIL rdsame_data_out got %h want 77", data_out); end
    checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL rdsame_valid got %b want 1", data_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rdsame_overrun got %b want 0", overrun); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    int fe0;
    d = 8'hFF;
    fe0 = fe_pulses;
    uart_rx = 1'b0;
    repeat (10) tick();
    for (int i = 0; i < 3; i++) begin
      uart_rx = d[i];
      repeat (10) tick();
    end
    uart_rx = d[3];
    repeat (3) tick();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    repeat (4) tick();
    for (int i = 4; i < 8; i++) begin
      uart_rx = d[i];
      repeat (10) tick();
    end
    uart_rx = 1'b1;
    repeat (15) tick();
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", data_valid); end
    checks++; if (busy_rx !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy_rx); end
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    while (obs_q.size() > 0) begin
      logic [7:0] o;
      logic [7:0] e;
      o = obs_q.pop_front();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      $display("rx byte %h expected %h", o, e);
      checks++; if (o !== e) begin errors++; $display("FAIL midrst_byte got %h want %h", o, e); end
    end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL midrst_missing got %0d pending want 0", exp_q.size()); exp_q.delete(); end
    checks++; if (data_out !== 8'h5A) begin errors++; $display("FAIL midrst_data_out got %h want 5a", data_out); end
    checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL midrst_valid2 got %b want 1", data_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL midrst_overrun got %b want 0", overrun); end
    checks++; if (fe_pulses !== fe0) begin errors++; $display("FAIL midrst_ferr got %0d want %0d", fe_pulses, fe0); end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    fe_pulses  = 0;
    fe_run     = 1'b0;
    fe_long    = 1'b0;
    busy_seen  = 1'b0;
    prev_valid = 1'b0;
    prev_out   = 8'h00;
    prev_ovr   = 1'b0;
    reset      = 1'b1;
    uart_rx    = 1'b1;
    data_rd    = 1'b0;

    test_reset();
    test_frame_err();
    test_false_start();
    test_good_frame();
    test_back_to_back();
    test_rd_same_cycle();
    test_reset_mid_frame();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
